// File: rtl/dma_done_irq_coalescer.sv
// dma_done_irq_coalescer: DMA transfer ID tracking with count/timeout coalesced completion interrupt
module dma_done_irq_coalescer #(
  parameter int IdWidth      = 32,
  parameter int CntWidth     = 16,
  parameter int TimeoutWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_i,
  input  logic                    retire_i,
  input  logic                    rsp_err_i,
  input  logic                    cfg_irq_en_i,
  input  logic [CntWidth-1:0]     cfg_threshold_i,
  input  logic [TimeoutWidth-1:0] cfg_timeout_i,
  input  logic                    irq_ack_i,
  output logic [IdWidth-1:0]      next_id_o,
  output logic [IdWidth-1:0]      done_id_o,
  output logic [CntWidth-1:0]     outstanding_o,
  output logic [CntWidth-1:0]     unacked_o,
  output logic                    irq_o,
  output logic                    err_o,
  output logic                    busy_o
);
  typedef enum logic [1:0] {IDLE, ACCUM, IRQ} state_t;
  localparam logic [CntWidth-1:0] CNT_ONE = CntWidth'(1);
  localparam logic [CntWidth-1:0] CNT_MAX = '1;
  localparam logic [TimeoutWidth-1:0] TMO_ONE = TimeoutWidth'(1);
  localparam logic [TimeoutWidth-1:0] TMO_MAX = '1;
  state_t state, state_n;
  logic [TimeoutWidth-1:0] timer, timer_n;
  logic [CntWidth-1:0] thr, out_n, unacked_n;
  logic err_n, tmo_hit, trig;
  // Next-value logic for counters, sticky error and the coalescing trigger
  always_comb begin
    thr = (cfg_threshold_i == '0) ? CNT_ONE : cfg_threshold_i;
    out_n = (issue_i && !retire_i && outstanding_o != CNT_MAX) ? outstanding_o + CNT_ONE :
            (retire_i && !issue_i && outstanding_o != '0) ? outstanding_o - CNT_ONE : outstanding_o;
    unacked_n = irq_ack_i ? CntWidth'(retire_i) :
                (retire_i && unacked_o != CNT_MAX) ? unacked_o + CNT_ONE : unacked_o;
    err_n = (retire_i && (rsp_err_i || outstanding_o == '0)) || (err_o && !irq_ack_i);
    tmo_hit = cfg_timeout_i != '0 && !retire_i && timer >= cfg_timeout_i - TMO_ONE;
    trig = cfg_irq_en_i && (unacked_n >= thr || tmo_hit);
  end
  // State transitions; an ack always leaves IRQ/ACCUM without re-triggering in the same cycle
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = !retire_i ? IDLE : trig ? IRQ : ACCUM;
      ACCUM:   state_n = irq_ack_i ? (retire_i ? ACCUM : IDLE) : trig ? IRQ : ACCUM;
      IRQ:     state_n = irq_ack_i ? (retire_i ? ACCUM : IDLE) :
                         !cfg_irq_en_i ? (unacked_n == '0 ? IDLE : ACCUM) : IRQ;
      default: state_n = IDLE;
    endcase
    timer_n = (state_n != ACCUM || retire_i) ? '0 : (timer == TMO_MAX ? timer : timer + TMO_ONE);
  end
  // Registered state, counters and outputs; irq_o decodes the next state so it lines up with IRQ
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      timer         <= '0;
      next_id_o     <= IdWidth'(1);
      done_id_o     <= '0;
      outstanding_o <= '0;
      unacked_o     <= '0;
      irq_o         <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      next_id_o     <= next_id_o + IdWidth'(issue_i);
      done_id_o     <= done_id_o + IdWidth'(retire_i);
      outstanding_o <= out_n;
      unacked_o     <= unacked_n;
      irq_o         <= state_n == IRQ;
      err_o         <= err_n;
    end
  end
  assign busy_o = outstanding_o != '0;
endmodule

// File: tb/tb_dma_done_irq_coalescer.sv
// tb_dma_done_irq_coalescer: table-driven check of the coalescer plus wrap and async-reset sequences
module tb_dma_done_irq_coalescer;
  logic clk = 1'b0, rst = 1'b1;
  logic issue, retire, rsp_err, en, ack;
  logic [15:0] thr, tmo;
  logic [31:0] next_id, done_id;
  logic [15:0] outstanding, unacked;
  logic irq, err, busy;
  logic [3:0] next4, done4, out4, un4;
  logic irq4, err4, busy4;
  int nvec = 0, nbad = 0;
  typedef struct {
    logic is, re, er, en, ak;
    int th, tm, nx, dn, ot, un;
    logic iq, ee;
  } vec_t;
  vec_t vecs[$];
  always #5 clk = ~clk;
  dma_done_irq_coalescer dut (
    .clk_i(clk), .rst_i(rst), .issue_i(issue), .retire_i(retire), .rsp_err_i(rsp_err),
    .cfg_irq_en_i(en), .cfg_threshold_i(thr), .cfg_timeout_i(tmo), .irq_ack_i(ack),
    .next_id_o(next_id), .done_id_o(done_id), .outstanding_o(outstanding), .unacked_o(unacked),
    .irq_o(irq), .err_o(err), .busy_o(busy)
  );
  dma_done_irq_coalescer #(.IdWidth(4), .CntWidth(4), .TimeoutWidth(16)) dut4 (
    .clk_i(clk), .rst_i(rst), .issue_i(issue), .retire_i(retire), .rsp_err_i(rsp_err),
    .cfg_irq_en_i(en), .cfg_threshold_i(thr[3:0]), .cfg_timeout_i(tmo), .irq_ack_i(ack),
    .next_id_o(next4), .done_id_o(done4), .outstanding_o(out4), .unacked_o(un4),
    .irq_o(irq4), .err_o(err4), .busy_o(busy4)
  );
  task automatic add(input logic is, re, er, en_, ak, input int th, tm, nx, dn, ot, un, input logic iq, ee);
    vec_t v;
    v = '{is, re, er, en_, ak, th, tm, nx, dn, ot, un, iq, ee};
    vecs.push_back(v);
  endtask
  task automatic drive(input logic is, re, er, en_, ak, input int th, tm);
    issue = is; retire = re; rsp_err = er; en = en_; ack = ak;
    thr = 16'(th); tmo = 16'(tm);
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input int nx, dn, ot, un, input logic iq, ee);
    nvec++;
    if (int'(next_id) != nx || int'(done_id) != dn || int'(outstanding) != ot || int'(unacked) != un ||
        irq !== iq || err !== ee || busy !== (ot != 0)) begin
      nbad++;
      $display("FAIL %s: got next=%0d done=%0d out=%0d un=%0d irq=%b err=%b busy=%b expected next=%0d done=%0d out=%0d un=%0d irq=%b err=%b busy=%b",
               nm, next_id, done_id, outstanding, unacked, irq, err, busy, nx, dn, ot, un, iq, ee, ot != 0);
    end
  endtask
  initial begin
    logic saw_irq;
    drive(0, 0, 0, 1, 0, 4, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_all("reset", 1, 0, 0, 0, 0, 0);
    add(1,0,0,1,0, 4,0,  2, 0,1,0, 0,0);
    add(1,0,0,1,0, 4,0,  3, 0,2,0, 0,0);
    add(1,0,0,1,0, 4,0,  4, 0,3,0, 0,0);
    add(0,1,0,1,0, 4,0,  4, 1,2,1, 0,0);
    add(0,1,0,1,0, 4,0,  4, 2,1,2, 0,0);
    add(0,1,0,1,0, 4,0,  4, 3,0,3, 0,0);
    add(0,0,0,1,1, 4,0,  4, 3,0,0, 0,0);
    add(1,0,0,1,0, 2,0,  5, 3,1,0, 0,0);
    add(1,0,0,1,0, 2,0,  6, 3,2,0, 0,0);
    add(1,0,0,1,0, 2,0,  7, 3,3,0, 0,0);
    add(0,1,0,1,0, 2,0,  7, 4,2,1, 0,0);
    add(0,1,0,1,0, 2,0,  7, 5,1,2, 1,0);
    add(0,1,0,1,1, 2,0,  7, 6,0,1, 0,0);
    add(0,0,0,1,0, 2,0,  7, 6,0,1, 0,0);
    add(0,0,0,1,1, 2,0,  7, 6,0,0, 0,0);
    add(1,0,0,1,0, 8,5,  8, 6,1,0, 0,0);
    add(1,0,0,1,0, 8,5,  9, 6,2,0, 0,0);
    add(0,1,0,1,0, 8,5,  9, 7,1,1, 0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,1,0, 8,5, 9,7,1,1, 0,0);
    add(0,0,0,1,0, 8,5,  9, 7,1,1, 1,0);
    add(1,0,0,1,1, 8,5, 10, 7,2,0, 0,0);
    add(0,1,0,1,0, 8,5, 10, 8,1,1, 0,0);
    add(0,0,0,1,0, 8,5, 10, 8,1,1, 0,0);
    add(0,0,0,1,0, 8,5, 10, 8,1,1, 0,0);
    add(0,1,0,1,0, 8,5, 10, 9,0,2, 0,0);
    for (int i = 0; i < 4; i++) add(0,0,0,1,0, 8,5, 10,9,0,2, 0,0);
    add(0,0,0,1,0, 8,5, 10, 9,0,2, 1,0);
    add(0,0,0,1,1, 8,5, 10, 9,0,0, 0,0);
    add(1,0,0,1,0, 8,0, 11, 9,1,0, 0,0);
    add(1,0,0,1,0, 8,0, 12, 9,2,0, 0,0);
    add(0,1,1,1,0, 8,0, 12,10,1,1, 0,1);
    add(0,1,0,1,0, 8,0, 12,11,0,2, 0,1);
    add(0,0,0,1,1, 8,0, 12,11,0,0, 0,0);
    add(0,1,0,1,0, 8,0, 12,12,0,1, 0,1);
    add(0,0,0,1,1, 8,0, 12,12,0,0, 0,0);
    add(1,0,0,1,0, 8,0, 13,12,1,0, 0,0);
    add(1,1,0,1,0, 8,0, 14,13,1,1, 0,0);
    add(0,1,0,0,0, 1,0, 14,14,0,2, 0,0);
    add(0,0,0,1,0, 1,0, 14,14,0,2, 1,0);
    add(0,0,0,0,0, 1,0, 14,14,0,2, 0,0);
    add(0,0,0,1,0, 8,0, 14,14,0,2, 0,0);
    add(0,0,0,1,0, 2,0, 14,14,0,2, 1,0);
    add(0,0,0,1,1, 2,0, 14,14,0,0, 0,0);
    add(1,0,0,1,0, 0,0, 15,14,1,0, 0,0);
    add(0,1,0,1,0, 0,0, 15,15,0,1, 1,0);
    add(0,0,0,1,1, 0,0, 15,15,0,0, 0,0);
    foreach (vecs[i]) begin
      drive(vecs[i].is, vecs[i].re, vecs[i].er, vecs[i].en, vecs[i].ak, vecs[i].th, vecs[i].tm);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].nx, vecs[i].dn, vecs[i].ot, vecs[i].un, vecs[i].iq, vecs[i].ee);
    end
    drive(0, 0, 0, 1, 0, 8, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 0, 1, 0, 8, 0);
      step();
      if (i >= 14) begin
        chk($sformatf("wrap_next%0d", i), int'(next4), (1 + i) % 16);
        chk($sformatf("sat_out%0d", i), int'(out4), i < 15 ? i : 15);
      end
    end
    drive(1, 1, 0, 1, 0, 8, 0);
    step();
    chk("both_next", int'(next4), 2);
    chk("both_done", int'(done4), 1);
    chk("both_out", int'(out4), 15);
    drive(0, 0, 0, 1, 0, 8, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1, 0, 8, 0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 0, 8, 0);
      step();
    end
    drive(0, 0, 0, 1, 0, 8, 0);
    chk_all("pre_rst", 6, 5, 0, 5, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 0);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 1, 0, 0, 0, 0, 0);
    saw_irq = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      saw_irq = saw_irq | irq;
    end
    chk("no_irq_after_rst", int'(saw_irq), 0);
    chk_all("post_rst", 1, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
